// File: rtl/card_pkg.sv
// Shared definitions for the card-entry path: FSM encoding, card length and
// the digit/index widths seen by the Luhn checker and the display.
package card_pkg;

    localparam int NUM_DIGITS = 16;
    localparam int DIGIT_W    = 4;
    localparam int IDX_W      = 4;
    localparam int CNT_W      = 5;
    localparam int NUM_SW     = 10;

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_READY = 2'd1,
        ST_SERVE = 2'd2
    } card_state_t;

endpackage

// File: rtl/key_debounce.sv
// Active-low pushbutton conditioner: 2-flop synchronizer, stability counter,
// and a one-cycle press pulse on the accepted 1->0 transition.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic RESET_N,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic [CW-1:0] cnt_reg;
    logic          press_reg;

    // Reset to the released level so reset release never produces a press.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            cnt_reg   <= '0;
            press_reg <= 1'b0;
        end else begin
            sync1_reg <= key_n;
            sync2_reg <= sync1_reg;
            press_reg <= 1'b0;
            if (sync2_reg != level_reg) begin
                if (cnt_reg == LAST_CNT) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                    press_reg <= ~sync2_reg;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/card_digit_buffer.sv
// Collects a card number from one-hot switches and pushbuttons, then serves the
// digits last-to-first to the Luhn checker on each shift_pulse.
module card_digit_buffer
    import card_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NUM_DIGITS      = card_pkg::NUM_DIGITS
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic [NUM_SW-1:0]    sw,
    input  logic                 key_enter_n,
    input  logic                 key_back_n,
    input  logic                 key_start_n,
    input  logic                 shift_pulse,
    output logic [DIGIT_W-1:0]   card_digit,
    output logic                 luhn_on,
    output logic [DIGIT_W-1:0]   sel_digit,
    output logic                 sel_valid,
    output logic [CNT_W-1:0]     count,
    output logic [1:0]           state
);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

    logic [2:0] keys_n;
    logic [2:0] events;
    logic       ev_enter;
    logic       ev_back;
    logic       ev_start;

    assign keys_n   = {key_start_n, key_back_n, key_enter_n};
    assign ev_enter = events[0];
    assign ev_back  = events[1];
    assign ev_start = events[2];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_key (
                .CLOCK_50(CLOCK_50),
                .RESET_N (RESET_N),
                .key_n   (keys_n[gi]),
                .press   (events[gi])
            );
        end
    endgenerate

    logic [3:0] ones;

    always_comb begin
        ones      = '0;
        sel_digit = '0;
        for (int i = 0; i < NUM_SW; i++) begin
            if (sw[i]) begin
                ones      = ones + 4'd1;
                sel_digit = DIGIT_W'(i);
            end
        end
        sel_valid = (ones == 4'd1);
        if (!sel_valid) sel_digit = '0;
    end

    card_state_t        state_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [IDX_W-1:0]   rd_idx_reg;
    logic [DIGIT_W-1:0] card_digit_reg;
    logic               luhn_on_reg;
    logic [DIGIT_W-1:0] digits_reg [NUM_DIGITS];

    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] count_dec;
    logic [IDX_W-1:0] rd_idx_dec;

    assign count_inc  = count_reg + 1'b1;
    assign count_dec  = count_reg - 1'b1;
    assign rd_idx_dec = rd_idx_reg - 1'b1;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg      <= ST_ENTRY;
            count_reg      <= '0;
            rd_idx_reg     <= '0;
            card_digit_reg <= '0;
            luhn_on_reg    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) digits_reg[i] <= '0;
        end else begin
            case (state_reg)
                ST_ENTRY: begin
                    // Back has priority over a simultaneous enter.
                    if (ev_back) begin
                        if (count_reg != '0) begin
                            count_reg <= count_dec;
                            digits_reg[count_dec[IDX_W-1:0]] <= '0;
                        end
                    end else if (ev_enter && sel_valid) begin
                        digits_reg[count_reg[IDX_W-1:0]] <= sel_digit;
                        count_reg <= count_inc;
                        if (count_inc == FULL_COUNT) state_reg <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (ev_back) begin
                        count_reg            <= FULL_COUNT - 1'b1;
                        digits_reg[LAST_IDX] <= '0;
                        state_reg            <= ST_ENTRY;
                    end else if (ev_start) begin
                        rd_idx_reg     <= LAST_IDX;
                        card_digit_reg <= digits_reg[LAST_IDX];
                        luhn_on_reg    <= 1'b1;
                        state_reg      <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (shift_pulse && rd_idx_reg != '0) begin
                        rd_idx_reg     <= rd_idx_dec;
                        card_digit_reg <= digits_reg[rd_idx_dec];
                    end
                end
                default: begin
                    state_reg      <= ST_ENTRY;
                    card_digit_reg <= '0;
                    luhn_on_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign card_digit = card_digit_reg;
    assign luhn_on    = luhn_on_reg;
    assign count      = count_reg;
    assign state      = state_reg;

endmodule
